apb_regfile_slave_ws: RTL and testbench
=======================================

Name: apb_regfile_slave_ws

Overview:
Parametrised APB4 completer holding a word-addressed register file. It succeeds the zero-wait 8-bit register slave and adds the following:
- configurable wait states
- byte strobes
- a read-only ID register
- real PSLVERR error responses for out-of-range addresses and illegal writes
- a driven (non-tristate) read bus
It sits behind the APB bridge as a generic peripheral configuration/scratch block.

Parameters:
ADDR_WIDTH, 5, width of PADDR; word address (PADDR selects a word directly, no byte offset bits)
DATA_WIDTH, 32, data bus width; must be a multiple of 8
DEPTH, 32, number of implemented words; 2 <= DEPTH <= 2**ADDR_WIDTH
WAIT_STATES, 1, access-phase cycles with PREADY=0 before completion; 0..15
ID_VALUE, 32'h0000_0001, constant returned by word 0 (read-only); truncated/zero-extended to DATA_WIDTH

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  completer select
PENABLE  in  1  access phase indicator
PADDR  in  ADDR_WIDTH  word address
PWRITE  in  1  1=write, 0=read
PWDATA  in  DATA_WIDTH  write data
PSTRB  in  DATA_WIDTH/8  write byte-lane enables; ignored on reads
PRDATA  out  DATA_WIDTH  read data, registered
PREADY  out  1  transfer completion, registered
PSLVERR  out  1  error response, valid only while PREADY=1

Behaviour:
- Reset is PRESETn, asynchronous, active-low; clock is PCLK.
- Reset state:
  - state=IDLE.
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - Words 1..DEPTH-1 = 0; wait counter = 0.
- FSM states IDLE, WAIT, DONE:
  - IDLE, PSEL=1 and PENABLE=0 (setup phase):
    - Latch PADDR, PWRITE, PWDATA, PSTRB.
    - Compute err (below).
    - If WAIT_STATES=0, go to DONE; else load counter=WAIT_STATES-1 and go to WAIT.
  - WAIT: PREADY=0.
    - Counter=0 -> DONE; else decrement.
    - PSEL=0 -> abort to IDLE, no side effects.
  - DONE: PREADY=1, PSLVERR=err, PRDATA valid for reads.
    - On the edge with PSEL&PENABLE: commit the write if PWRITE and !err, then go to IDLE.
    - PSEL=0 -> IDLE, no write.
- Latency: PREADY is first high in access-phase cycle WAIT_STATES+1. Each transfer therefore takes WAIT_STATES+2 cycles, and back-to-back transfers have no extra gap.
- err conditions:
  - Latched address >= DEPTH (read or write).
  - Write to address 0 (ID register).
  - Write with PSTRB=0 is legal: no error, no change.
- Read data:
  - Loaded into PRDATA on the edge entering DONE: word[addr], with word 0 = ID_VALUE, or 0 if err.
  - PRDATA returns to 0 on the exit edge from DONE.
  - PRDATA is never high-Z.
- Write commit:
  - Byte lane i of word[addr] is updated with PWDATA[8i+7:8i] iff PSTRB[i]=1.
  - Other lanes are unchanged.
  - Updated data is visible to the next transfer.
- PSLVERR is 0 whenever PREADY=0; it is cleared on the exit edge from DONE.
- Address/data/strobe are sampled only at setup. Changes during the access phase are ignored (protocol violation; no checking).
- PENABLE=1 while in IDLE (no preceding setup) is ignored; the block stays in IDLE.
- Reset asserted mid-transfer: immediate return to reset state. Any pending write is discarded and register contents are re-zeroed.

Test Plan:
- Params DATA_WIDTH=32, DEPTH=24, WAIT_STATES=2, ID_VALUE=32'hA5B0_0001. Reset, then read addr 0 -> PREADY low for 2 access cycles, high on the 3rd; PRDATA=32'hA5B0_0001, PSLVERR=0.
- Write addr 5 = 32'hDEAD_BEEF with PSTRB=4'hF, then read addr 5 -> 32'hDEAD_BEEF. Write 32'h1122_3344 with PSTRB=4'b0101, then read -> 32'hDE22_BE44.
- Write addr 0 = 32'hFFFF_FFFF -> PSLVERR=1 with PREADY; subsequent read addr 0 -> 32'hA5B0_0001.
- Read addr 30 (>= DEPTH) -> PSLVERR=1, PRDATA=0. Write addr 24 -> PSLVERR=1, and no word changes (spot-check addr 0..23 unchanged).
- WAIT_STATES=0 build: back-to-back write addr 3=32'h0000_00AA then read addr 3 -> each transfer 2 cycles, PREADY high in the first access cycle, read returns 32'h0000_00AA.
- Write addr 7 with PRESETn pulsed low during WAIT -> outputs 0 immediately, state IDLE; read addr 7 after reset -> 0, and the next transfer completes normally.

Source files
------------

// File: rtl/apb_regfile_slave_ws.sv
// APB4 completer with a word-addressed register file, programmable wait states,
// byte strobes, a read-only ID word at address 0 and PSLVERR on bad accesses.
`timescale 1ns/1ps
module apb_regfile_slave_ws #(
  parameter int          ADDR_WIDTH  = 5,
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH       = 32,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h0000_0001
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int         NB      = DATA_WIDTH / 8;
  localparam int         NWORDS  = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic                    write_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [NB-1:0]           strb_reg;
  logic                    err_reg;
  logic [3:0]              cnt_reg;
  logic                    setup_err;
  logic                    commit;
  logic [DATA_WIDTH-1:0]   rd_vec [NWORDS];

  // Out-of-range check is done one bit wider so DEPTH == 2**ADDR_WIDTH works.
  assign setup_err = ({1'b0, PADDR} >= (ADDR_WIDTH + 1)'(DEPTH)) || (PWRITE && (PADDR == '0));
  assign commit    = (state_reg == DONE) && PSEL && PENABLE && write_reg && !err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NWORDS; gi++) begin : g_word
      if (gi == 0) begin : g_id
        assign rd_vec[gi] = DATA_WIDTH'(ID_VALUE);
      end else if (gi < DEPTH) begin : g_reg
        logic [DATA_WIDTH-1:0] word_reg;
        always_ff @(posedge PCLK or negedge PRESETn) begin
          if (!PRESETn) begin
            word_reg <= '0;
          end else if (commit && (addr_reg == ADDR_WIDTH'(gi))) begin
            for (int b = 0; b < NB; b++) begin
              if (strb_reg[b]) word_reg[8*b +: 8] <= wdata_reg[8*b +: 8];
            end
          end
        end
        assign rd_vec[gi] = word_reg;
      end else begin : g_unimpl
        assign rd_vec[gi] = '0;
      end
    end
  endgenerate

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      write_reg <= 1'b0;
      wdata_reg <= '0;
      strb_reg  <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      PRDATA    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            addr_reg  <= PADDR;
            write_reg <= PWRITE;
            wdata_reg <= PWDATA;
            strb_reg  <= PSTRB;
            err_reg   <= setup_err;
            if (WAIT_STATES == 0) begin
              state_reg <= DONE;
              PREADY    <= 1'b1;
              PSLVERR   <= setup_err;
              PRDATA    <= (!PWRITE && !setup_err) ? rd_vec[PADDR] : '0;
            end else begin
              cnt_reg   <= WS_LOAD;
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!PSEL) begin
            state_reg <= IDLE;
          end else if (cnt_reg == '0) begin
            state_reg <= DONE;
            PREADY    <= 1'b1;
            PSLVERR   <= err_reg;
            PRDATA    <= (!write_reg && !err_reg) ? rd_vec[addr_reg] : '0;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        DONE: begin
          // The write itself is committed by the word registers on this same edge.
          if (!PSEL || PENABLE) begin
            state_reg <= IDLE;
            PREADY    <= 1'b0;
            PSLVERR   <= 1'b0;
            PRDATA    <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave_ws.sv
// Directed bench: a 2-wait-state/24-word instance and a zero-wait instance
// share one bus; the select line decides which one a transfer targets.
`timescale 1ns/1ps
module tb_apb_regfile_slave_ws;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        psel_a, psel_b, PENABLE, PWRITE;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b;
  bit          dsel;
  logic [31:0] cur_prdata;
  logic        cur_ready, cur_pslverr;

  always #5 PCLK = ~PCLK;

  assign cur_prdata  = dsel ? prdata_b  : prdata_a;
  assign cur_ready   = dsel ? pready_b  : pready_a;
  assign cur_pslverr = dsel ? pslverr_b : pslverr_a;

  apb_regfile_slave_ws #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(24), .WAIT_STATES(2),
                         .ID_VALUE(32'hA5B0_0001)) dut_a (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel_a), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a));

  apb_regfile_slave_ws #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(32), .WAIT_STATES(0),
                         .ID_VALUE(32'h0000_0001)) dut_b (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel_b), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b));

  typedef struct {
    bit          d;
    bit          wr;
    logic [4:0]  a;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] erd;
    logic        eerr;
    int          eacc;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input bit d, input bit wr, input logic [4:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input logic [31:0] erd, input logic eerr,
                     input string name);
    vec_t v;
    v.d = d; v.wr = wr; v.a = a; v.wd = wd; v.st = st;
    v.erd = erd; v.eerr = eerr; v.eacc = d ? 1 : 3; v.name = name;
    vecs.push_back(v);
  endtask

  // Starts at posedge+1 and returns at posedge+1 just after the completion edge.
  task automatic xfer(input bit d, input bit wr, input logic [4:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic er,
                      output int acc, output bit early_err);
    dsel = d; psel_a = !d; psel_b = d; PENABLE = 1'b0;
    PWRITE = wr; PADDR = a; PWDATA = wd; PSTRB = st;
    early_err = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    acc = 1;
    while (!cur_ready && acc < 40) begin
      if (cur_pslverr) early_err = 1'b1;
      @(posedge PCLK); #1;
      acc++;
    end
    rd = cur_prdata;
    er = cur_pslverr;
    @(posedge PCLK); #1;
    psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic run_check(input bit d, input bit wr, input logic [4:0] a, input logic [31:0] wd,
                           input logic [3:0] st, input logic [31:0] erd, input logic eerr,
                           input int eacc, input string name);
    logic [31:0] rd;
    logic        er;
    int          acc;
    bit          early;
    xfer(d, wr, a, wd, st, rd, er, acc, early);
    check({name, "_latency"}, 32'(acc), 32'(eacc));
    check({name, "_pslverr"}, {31'd0, er}, {31'd0, eerr});
    if (!wr) check({name, "_prdata"}, rd, erd);
    check({name, "_err_before_ready"}, {31'd0, early}, 32'd0);
    check({name, "_exit_ready"}, {31'd0, cur_ready}, 32'd0);
    check({name, "_exit_prdata"}, cur_prdata, 32'd0);
    $display("xfer %-14s dut=%0d %s addr=%0d acc=%0d rdata=%h err=%0d",
             name, d, wr ? "W" : "R", a, acc, rd, er);
  endtask

  initial begin
    PRESETn = 1'b0; psel_a = 0; psel_b = 0; PENABLE = 0; PWRITE = 0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; dsel = 0;

    add(0, 0, 5'd0,  32'h0,         4'h0,    32'hA5B0_0001, 0, "rd_id");
    add(0, 1, 5'd5,  32'hDEAD_BEEF, 4'hF,    32'h0,         0, "wr5_full");
    add(0, 0, 5'd5,  32'h0,         4'h0,    32'hDEAD_BEEF, 0, "rd5_full");
    add(0, 1, 5'd5,  32'h1122_3344, 4'b0101, 32'h0,         0, "wr5_strb");
    add(0, 0, 5'd5,  32'h0,         4'h0,    32'hDE22_BE44, 0, "rd5_strb");
    add(0, 1, 5'd0,  32'hFFFF_FFFF, 4'hF,    32'h0,         1, "wr_id");
    add(0, 0, 5'd0,  32'h0,         4'h0,    32'hA5B0_0001, 0, "rd_id_again");
    add(0, 0, 5'd30, 32'h0,         4'h0,    32'h0,         1, "rd30_oor");
    add(0, 1, 5'd24, 32'hFFFF_FFFF, 4'hF,    32'h0,         1, "wr24_oor");
    add(0, 1, 5'd23, 32'h0BAD_CAFE, 4'h0,    32'h0,         0, "wr23_nostrb");
    add(0, 0, 5'd23, 32'h0,         4'h0,    32'h0,         0, "rd23");
    add(1, 1, 5'd3,  32'h0000_00AA, 4'hF,    32'h0,         0, "b_wr3");
    add(1, 0, 5'd3,  32'h0,         4'h0,    32'h0000_00AA, 0, "b_rd3");
    add(1, 1, 5'd31, 32'h8765_4321, 4'b1000, 32'h0,         0, "b_wr31");
    add(1, 0, 5'd31, 32'h0,         4'h0,    32'h8700_0000, 0, "b_rd31");
    add(1, 0, 5'd0,  32'h0,         4'h0,    32'h0000_0001, 0, "b_rd_id");

    repeat (2) @(posedge PCLK);
    #1;
    check("rst_ready_a",   {31'd0, pready_a},  32'd0);
    check("rst_pslverr_a", {31'd0, pslverr_a}, 32'd0);
    check("rst_prdata_a",  prdata_a,           32'd0);
    check("rst_ready_b",   {31'd0, pready_b},  32'd0);
    check("rst_prdata_b",  prdata_b,           32'd0);
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;

    foreach (vecs[i])
      run_check(vecs[i].d, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].st,
                vecs[i].erd, vecs[i].eerr, vecs[i].eacc, vecs[i].name);

    // The illegal writes above must have left every word intact.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] exp;
      exp = (i == 0) ? 32'hA5B0_0001 : (i == 5) ? 32'hDE22_BE44 : 32'h0;
      run_check(0, 0, 5'(i), 32'h0, 4'h0, exp, 0, 3, $sformatf("spot%0d", i));
    end

    // PENABLE without a setup phase must not start a transfer.
    dsel = 0; psel_a = 1; PENABLE = 1; PWRITE = 1; PADDR = 5'd9; PWDATA = 32'hFFFF_FFFF; PSTRB = 4'hF;
    repeat (4) @(posedge PCLK);
    #1;
    check("penable_only_ready", {31'd0, pready_a}, 32'd0);
    psel_a = 0; PENABLE = 0;
    @(posedge PCLK); #1;
    run_check(0, 0, 5'd9, 32'h0, 4'h0, 32'h0, 0, 3, "rd9_after_penable");

    // Deselect during the wait phase: abort, no write.
    psel_a = 1; PENABLE = 0; PWRITE = 1; PADDR = 5'd8; PWDATA = 32'hFFFF_FFFF; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1;
    @(posedge PCLK); #1;
    psel_a = 0; PENABLE = 0;
    @(posedge PCLK); #1;
    check("abort_ready", {31'd0, pready_a}, 32'd0);
    @(posedge PCLK); #1;
    check("abort_ready_late", {31'd0, pready_a}, 32'd0);
    run_check(0, 0, 5'd8, 32'h0, 4'h0, 32'h0, 0, 3, "rd8_after_abort");

    // Reset pulse while a write to word 7 is waiting.
    psel_a = 1; PENABLE = 0; PWRITE = 1; PADDR = 5'd7; PWDATA = 32'h55AA_55AA; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1;
    #1 PRESETn = 1'b0;
    #1;
    check("midrst_ready",   {31'd0, pready_a},  32'd0);
    check("midrst_pslverr", {31'd0, pslverr_a}, 32'd0);
    check("midrst_prdata",  prdata_a,           32'd0);
    psel_a = 0; PENABLE = 0;
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;
    run_check(0, 0, 5'd7, 32'h0, 4'h0, 32'h0, 0, 3, "rd7_after_rst");
    run_check(0, 0, 5'd5, 32'h0, 4'h0, 32'h0, 0, 3, "rd5_rezeroed");
    run_check(1, 0, 5'd3, 32'h0, 4'h0, 32'h0, 0, 1, "b_rd3_rezeroed");
    run_check(0, 1, 5'd9, 32'hCAFE_F00D, 4'hF, 32'h0, 0, 3, "wr9_post_rst");
    run_check(0, 0, 5'd9, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 3, "rd9_post_rst");

    // Reset while a read is being presented must clear the outputs at once.
    dsel = 0; psel_a = 1; PENABLE = 0; PWRITE = 0; PADDR = 5'd0;
    @(posedge PCLK); #1;
    PENABLE = 1;
    repeat (2) @(posedge PCLK);
    #1;
    check("done_ready",  {31'd0, pready_a}, 32'd1);
    check("done_prdata", prdata_a,          32'hA5B0_0001);
    #1 PRESETn = 1'b0;
    #1;
    check("donerst_ready",  {31'd0, pready_a}, 32'd0);
    check("donerst_prdata", prdata_a,          32'd0);
    psel_a = 0; PENABLE = 0;
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;
    run_check(0, 0, 5'd9, 32'h0, 4'h0, 32'h0, 0, 3, "rd9_rezeroed");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
